// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the two requester ports and the SDRAM controller command/read-data port.
// The arbiter uses the slave modport; a requester/controller model uses master.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 32,
  parameter int RD_DEPTH = 4
) ();
  localparam int CNT_W = $clog2(RD_DEPTH) + 1;

  // Requester port 0
  logic              p0_req;
  logic              p0_wr;
  logic [ADDR_W-1:0] p0_addr;
  logic [3:0]        p0_be;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_rvalid;

  // Requester port 1
  logic              p1_req;
  logic              p1_wr;
  logic [ADDR_W-1:0] p1_addr;
  logic [3:0]        p1_be;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_rvalid;

  // Controller side
  logic              cmd_ready;
  logic              cmd_enable;
  logic              cmd_wr;
  logic [3:0]        cmd_byte_enable;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_out_ready;

  // Status
  logic [CNT_W-1:0]  rd_pending;
  logic              err_orphan;
  logic [1:0]        dbg_state;

  modport slave (
    input  p0_req, p0_wr, p0_addr, p0_be, p0_wdata,
    output p0_ack, p0_rdata, p0_rvalid,
    input  p1_req, p1_wr, p1_addr, p1_be, p1_wdata,
    output p1_ack, p1_rdata, p1_rvalid,
    input  cmd_ready, data_out, data_out_ready,
    output cmd_enable, cmd_wr, cmd_byte_enable, cmd_address, cmd_data_in,
    output rd_pending, err_orphan, dbg_state
  );

  modport master (
    output p0_req, p0_wr, p0_addr, p0_be, p0_wdata,
    input  p0_ack, p0_rdata, p0_rvalid,
    output p1_req, p1_wr, p1_addr, p1_be, p1_wdata,
    input  p1_ack, p1_rdata, p1_rvalid,
    output cmd_ready, data_out, data_out_ready,
    input  cmd_enable, cmd_wr, cmd_byte_enable, cmd_address, cmd_data_in,
    input  rd_pending, err_orphan, dbg_state
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port between two requesters,
// with a tag FIFO that steers each returned read word back to the port that issued it.
module sdram_port_arbiter #(
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 32,
  parameter int RD_DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  sdram_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(RD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a command transfers in any cycle where cmd_enable and cmd_ready are both
  // high; cmd_enable and the payload stay fixed from the ISSUE entry until that cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_port_q, gnt_port_d;
  logic              cmd_en_q, cmd_en_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [3:0]        cmd_be_q, cmd_be_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [RD_DEPTH-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              orphan_q, orphan_d;

  logic              rd_room;
  logic              elig0;
  logic              elig1;
  logic              pick;
  logic              push;
  logic              pop;
  logic              head;

  assign rd_room = (cnt_q < CNT_W'(RD_DEPTH));
  assign elig0   = bus.p0_req && (bus.p0_wr || rd_room);
  assign elig1   = bus.p1_req && (bus.p1_wr || rd_room);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_port_d   = gnt_port_q;
    cmd_en_d     = cmd_en_q;
    cmd_wr_d     = cmd_wr_q;
    cmd_be_d     = cmd_be_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_data_d   = cmd_data_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    pick         = 1'b0;
    push         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_ready && (elig0 || elig1)) begin
          // On a tie the port that did not win last time goes next.
          pick         = (elig0 && elig1) ? ~last_grant_q : elig1;
          gnt_port_d   = pick;
          last_grant_d = pick;
          cmd_en_d     = 1'b1;
          cmd_wr_d     = pick ? bus.p1_wr    : bus.p0_wr;
          cmd_be_d     = pick ? bus.p1_be    : bus.p0_be;
          cmd_addr_d   = pick ? bus.p1_addr  : bus.p0_addr;
          cmd_data_d   = pick ? bus.p1_wdata : bus.p0_wdata;
          ack0_d       = ~pick;
          ack1_d       = pick;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_en_q && bus.cmd_ready) begin
          push     = ~cmd_wr_q;
          cmd_en_d = 1'b0;
          state_d  = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        cmd_en_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_comb begin
    tag_d     = tag_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    orphan_d  = orphan_q;
    pop       = bus.data_out_ready && (cnt_q != '0);
    head      = tag_q[rd_ptr_q];

    if (push) begin
      tag_d[wr_ptr_q] = gnt_port_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (head) begin
        rdata1_d  = bus.data_out;
        rvalid1_d = 1'b1;
      end else begin
        rdata0_d  = bus.data_out;
        rvalid0_d = 1'b1;
      end
    end

    if (bus.data_out_ready && (cnt_q == '0)) begin
      orphan_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_port_q   <= 1'b0;
      cmd_en_q     <= 1'b0;
      cmd_wr_q     <= 1'b0;
      cmd_be_q     <= '0;
      cmd_addr_q   <= '0;
      cmd_data_q   <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      orphan_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_port_q   <= gnt_port_d;
      cmd_en_q     <= cmd_en_d;
      cmd_wr_q     <= cmd_wr_d;
      cmd_be_q     <= cmd_be_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_data_q   <= cmd_data_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      orphan_q     <= orphan_d;
    end
  end

  assign bus.p0_ack          = ack0_q;
  assign bus.p1_ack          = ack1_q;
  assign bus.p0_rdata        = rdata0_q;
  assign bus.p1_rdata        = rdata1_q;
  assign bus.p0_rvalid       = rvalid0_q;
  assign bus.p1_rvalid       = rvalid1_q;
  assign bus.cmd_enable      = cmd_en_q;
  assign bus.cmd_wr          = cmd_wr_q;
  assign bus.cmd_byte_enable = cmd_be_q;
  assign bus.cmd_address     = cmd_addr_q;
  assign bus.cmd_data_in     = cmd_data_q;
  assign bus.rd_pending      = cnt_q;
  assign bus.err_orphan      = orphan_q;
  assign bus.dbg_state       = state_q;
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-port arbiter that shares the single command port of the SDRAM controller (the block with the `cmd_ready`/`cmd_enable` handshake) between two independent requesters, e.g. the test/debug sequencer and a UART/streaming client. It grants commands round-robin, registers the command payload, holds `cmd_enable` until the controller accepts it, and tracks outstanding reads in a tag FIFO. Each `data_out_ready` pulse is steered back to the port that issued that read. It sits in the `clk100` domain between the requesters and the controller.

## Interface
- `ADDR_W`, 23, word address width (matches controller `cmd_address`)
- `DATA_W`, 32, data width
- `RD_DEPTH`, 4, max outstanding reads (power of two, ≥2)

- `clk`  in  1  system clock (`clk100`)
- `reset`  in  1  asynchronous, active-high reset
- `pN_req`  in  1  port N (N=0,1) request; held with payload until `pN_ack`
- `pN_wr`  in  1  1 = write, 0 = read
- `pN_addr`  in  ADDR_W  address
- `pN_be`  in  4  byte enables (writes)
- `pN_wdata`  in  DATA_W  write data
- `pN_ack`  out  1  one-cycle pulse: request captured
- `pN_rdata`  out  DATA_W  read data
- `pN_rvalid`  out  1  one-cycle pulse: `pN_rdata` valid
- `cmd_ready`  in  1  controller can accept a command
- `cmd_enable`  out  1  command valid
- `cmd_wr`, `cmd_byte_enable[3:0]`, `cmd_address[ADDR_W-1:0]`, `cmd_data_in[DATA_W-1:0]`  out  registered payload
- `data_out`  in  DATA_W  controller read data
- `data_out_ready`  in  1  controller read-data strobe
- `rd_pending`  out  log2(RD_DEPTH)+1  outstanding read count
- `err_orphan`  out  1  sticky: read data arrived with no outstanding read

## Operation
- Reset values: all outputs 0. `last_grant` = 1, so port 0 wins the first tie. State = IDLE. Tag FIFO empty.
- Eligibility: port N is eligible when `pN_req`=1 and (`pN_wr`=1 or `rd_pending` < RD_DEPTH).
- IDLE:
  - Grant only when `cmd_ready`=1 and at least one port is eligible.
  - With one eligible port, that port wins. With both eligible, the port ≠ `last_grant` wins.
  - On grant, register the payload, update `last_grant`, and go to ISSUE. `pN_ack` and `cmd_enable` rise on the next edge.
- ISSUE:
  - `cmd_enable`=1 and the payload is stable.
  - Acceptance is `cmd_enable` & `cmd_ready` in the same cycle.
  - On acceptance: if the command is a read, push the granted port index into the tag FIFO; go to GAP.
  - If `cmd_ready`=0, stay in ISSUE and keep `cmd_enable` high.
  - `pN_ack` is high only on the first ISSUE cycle.
- GAP: one cycle with `cmd_enable`=0, which guarantees deassertion between commands. Then go to IDLE.
- Read return:
  - On `data_out_ready`=1 with the FIFO non-empty: pop the head tag T, and on the next edge drive `pT_rdata`=`data_out` and `pT_rvalid`=1 for one cycle.
  - The non-target port's `rvalid` stays 0 and its `rdata` holds its last value.
- Orphan data: `data_out_ready` with the FIFO empty sets `err_orphan`, which holds until reset. No `rvalid` is produced.
- Simultaneous push and pop in one cycle: both are performed and `rd_pending` is unchanged.
- FIFO pointers wrap modulo RD_DEPTH. `rd_pending` saturation is impossible by eligibility.
- A blocked read on one port does not block a write or an eligible request on the other port.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). In-flight reads are discarded. Requesters must re-issue.

## Timing
- Grant cycle (IDLE with eligible request and `cmd_ready`=1) → `cmd_enable`/`pN_ack` high on the next cycle: 1-cycle latency.
- Minimum command spacing: 3 cycles (IDLE → ISSUE → GAP).
- `data_out_ready` → `pN_rvalid`: 1 cycle, in FIFO (issue) order.
- The requester may change its payload or drop `pN_req` in the cycle after `pN_ack`.
- All outputs are registered.

## Test plan
- Port 0 write, addr 100, data 666, be 4'hF, `cmd_ready`=1 → `p0_ack` and `cmd_enable` one cycle after request; `cmd_wr`=1, `cmd_address`=100, `cmd_data_in`=666; `rd_pending` stays 0.
- Both ports request writes continuously → grants alternate 0,1,0,1, starting with port 0 after reset; each `cmd_enable` burst is followed by ≥1 low cycle.
- Port 0 read addr 100, then port 1 read addr 200. Model returns 666 then 777 → `p0_rvalid` with 666, then `p1_rvalid` with 777; `rd_pending` goes 0→1→2→1→0.
- Hold `cmd_ready`=0 for 5 cycles during ISSUE → `cmd_enable` stays high with a stable payload, and `pN_ack` pulses only once.
- Port 0 issues 4 reads with no return → 5th read stalls with no ack. A port 1 write is still granted. One `data_out_ready` → the stalled read is granted. A `data_out_ready` with an empty FIFO → `err_orphan`=1.
- Assert `reset` with 2 reads pending → `rd_pending`=0, `cmd_enable`=0, and no `rvalid` afterwards.
